// File: rtl/shift_flow_ctrl.sv
// ---------------------------------------------------------------------------
// shift_flow_ctrl
//
// Flow-control shell around a free-running pipelined barrel shifter.
// Requests arrive on a valid/ready handshake, are registered onto the shifter
// inputs and tagged in a valid shift register that mirrors the shifter's
// fixed latency. When a tag reaches the top of that register, the shifter
// output is captured into an output FIFO. The FIFO drains over a second
// valid/ready handshake.
//
// Credits: every launched operation has a FIFO slot reserved for it.
// The number of slots in use is the operations still inside the shifter
// plus the entries already in the FIFO. A request is accepted only while
// that total is below the FIFO depth. As a result, a capture can never
// find the FIFO full, and the shifter never needs to stall.
//
// Ports
//   Clock       in   single clock, all state on posedge
//   Reset       in   asynchronous, active-high
//   ReqValid    in   request present
//   ReqReady    out  request accepted when ReqValid is also high
//   ReqData     in   operand
//   ReqAmount   in   left-shift amount
//   ReqShiftIn  in   fill bit for vacated LSBs
//   ShIn        out  to shifter In (registered request operand)
//   ShAmount    out  to shifter ShiftAmount
//   ShShiftIn   out  to shifter ShiftIn
//   ShOut       in   from shifter Out
//   RespValid   out  FIFO head valid
//   RespReady   in   consumer takes head
//   RespData    out  FIFO head data (reads 0 when empty)
//   InFlight    out  operations currently inside the shifter
// ---------------------------------------------------------------------------
module shift_flow_ctrl #(
   parameter int DATAWIDTH = 32,
   parameter int LATENCY   = 5,
   parameter int OUTDEPTH  = 8
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         ReqValid,
   output logic                         ReqReady,
   input  logic [DATAWIDTH-1:0]         ReqData,
   input  logic [$clog2(DATAWIDTH)-1:0] ReqAmount,
   input  logic                         ReqShiftIn,
   output logic [DATAWIDTH-1:0]         ShIn,
   output logic [$clog2(DATAWIDTH)-1:0] ShAmount,
   output logic                         ShShiftIn,
   input  logic [DATAWIDTH-1:0]         ShOut,
   output logic                         RespValid,
   input  logic                         RespReady,
   output logic [DATAWIDTH-1:0]         RespData,
   output logic [$clog2(LATENCY+1):0]   InFlight
);

   localparam int AMTW  = $clog2(DATAWIDTH);
   localparam int IFW   = $clog2(LATENCY + 1) + 1;
   localparam int PTRW  = (OUTDEPTH > 1) ? $clog2(OUTDEPTH) : 1;
   localparam int CNTW  = $clog2(OUTDEPTH + 1);
   // Wide enough to hold InFlight + count without wrapping.
   localparam int USEDW = CNTW + IFW;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------

   // Number of set bits in the valid pipe, i.e. operations not yet captured.
   function automatic logic [IFW-1:0] countOnes(input logic [LATENCY:0] vec);
      logic [IFW-1:0] total;
      total = IFW'(0);
      for (int i = 0; i <= LATENCY; i++) begin
         total = total + IFW'(vec[i]);
      end
      return total;
   endfunction

   // Pointer increment with explicit wrap, so a depth that is not a power
   // of two still works.
   function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] ptr);
      logic [PTRW-1:0] nxt;
      if (ptr == PTRW'(OUTDEPTH - 1)) begin
         nxt = PTRW'(0);
      end else begin
         nxt = ptr + PTRW'(1);
      end
      return nxt;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATAWIDTH-1:0] shIn_r;
   logic [AMTW-1:0]      shAmount_r;
   logic                 shShiftIn_r;
   // Bit j set means an operation launched j+1 edges ago.
   // The top bit marks a result that is present on ShOut now.
   logic [LATENCY:0]     validPipe_r;

   logic [DATAWIDTH-1:0] fifoMem_r [OUTDEPTH];
   logic [PTRW-1:0]      wrPtr_r;
   logic [PTRW-1:0]      rdPtr_r;
   logic [CNTW-1:0]      fifoCount_r;

   logic                 accept_s;
   logic                 capture_s;
   logic                 pop_s;
   logic                 fifoEmpty_s;
   logic [IFW-1:0]       inFlight_s;
   logic [USEDW-1:0]     used_s;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------

   // Credit accounting and handshakes. These depend only on registered
   // state, apart from the two valid/ready ANDs.
   always_comb begin
      inFlight_s  = countOnes(validPipe_r);
      used_s      = USEDW'(inFlight_s) + USEDW'(fifoCount_r);
      fifoEmpty_s = (fifoCount_r == CNTW'(0));
      ReqReady    = (used_s < USEDW'(OUTDEPTH));
      RespValid   = !fifoEmpty_s;
      accept_s    = ReqValid & ReqReady;
      pop_s       = RespValid & RespReady;
      capture_s   = validPipe_r[LATENCY];
   end

   // FIFO head, forced to zero when empty so that stale storage never shows.
   always_comb begin
      RespData = {DATAWIDTH{1'b0}};
      if (fifoEmpty_s) begin
         RespData = {DATAWIDTH{1'b0}};
      end else begin
         RespData = fifoMem_r[rdPtr_r];
      end
   end

   assign ShIn      = shIn_r;
   assign ShAmount  = shAmount_r;
   assign ShShiftIn = shShiftIn_r;
   assign InFlight  = inFlight_s;

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------

   // Shifter operand registers: load on accept, otherwise hold.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         shIn_r      <= {DATAWIDTH{1'b0}};
         shAmount_r  <= {AMTW{1'b0}};
         shShiftIn_r <= 1'b0;
      end else if (accept_s) begin
         shIn_r      <= ReqData;
         shAmount_r  <= ReqAmount;
         shShiftIn_r <= ReqShiftIn;
      end
   end

   // The valid pipe advances every cycle, because the shifter never stalls.
   // Clearing it on reset discards any operations still in flight.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         validPipe_r <= {(LATENCY + 1){1'b0}};
      end else begin
         validPipe_r <= {validPipe_r[LATENCY-1:0], accept_s};
      end
   end

   // FIFO storage. It needs no reset, because RespData is gated by the count.
   always_ff @(posedge Clock) begin
      if (capture_s) begin
         fifoMem_r[wrPtr_r] <= ShOut;
      end
   end

   // FIFO pointers and occupancy. Full and empty are derived from the count.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wrPtr_r     <= PTRW'(0);
         rdPtr_r     <= PTRW'(0);
         fifoCount_r <= CNTW'(0);
      end else begin
         if (capture_s) begin
            wrPtr_r <= nextPtr(wrPtr_r);
         end
         if (pop_s) begin
            rdPtr_r <= nextPtr(rdPtr_r);
         end
         case ({capture_s, pop_s})
            2'b10:   fifoCount_r <= fifoCount_r + CNTW'(1);
            2'b01:   fifoCount_r <= fifoCount_r - CNTW'(1);
            default: fifoCount_r <= fifoCount_r;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_flow_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for shift_flow_ctrl. It contains a behavioural 5-stage shifter model,
// a negedge monitor that pushes expected results on each request handshake,
// and pops/compares them on each response handshake.
// ---------------------------------------------------------------------------
module tb_shift_flow_ctrl;

   localparam int DW    = 32;
   localparam int LAT   = 5;
   localparam int DEPTH = 8;

   logic          Clock;
   logic          Reset;
   logic          ReqValid;
   logic          ReqReady;
   logic [DW-1:0] ReqData;
   logic [4:0]    ReqAmount;
   logic          ReqShiftIn;
   logic [DW-1:0] ShIn;
   logic [4:0]    ShAmount;
   logic          ShShiftIn;
   logic [DW-1:0] ShOut;
   logic          RespValid;
   logic          RespReady;
   logic [DW-1:0] RespData;
   logic [3:0]    InFlight;

   int            testsRun     = 0;
   int            testsFailed  = 0;
   int            cyc          = 0;
   int            respCount    = 0;
   int            firstRespCyc = 0;
   int            lastRespCyc  = 0;
   int            stallCount   = 0;
   int            maxCount     = 0;
   logic [DW-1:0] expQ [$];
   logic [DW-1:0] shPipe [LAT];

   shift_flow_ctrl #(.DATAWIDTH(DW), .LATENCY(LAT), .OUTDEPTH(DEPTH)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .ReqData    (ReqData),
      .ReqAmount  (ReqAmount),
      .ReqShiftIn (ReqShiftIn),
      .ShIn       (ShIn),
      .ShAmount   (ShAmount),
      .ShShiftIn  (ShShiftIn),
      .ShOut      (ShOut),
      .RespValid  (RespValid),
      .RespReady  (RespReady),
      .RespData   (RespData),
      .InFlight   (InFlight)
   );

   // Reference left shift with fill.
   function automatic logic [DW-1:0] refShift(input logic [DW-1:0] d, input logic [4:0] a,
                                              input logic s);
      logic [DW-1:0] fill;
      fill = s ? ((32'd1 << a) - 32'd1) : 32'd0;
      return (d << a) | fill;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Clock generation.
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Cycle counter.
   always @(posedge Clock) cyc <= cyc + 1;

   // Free-running shifter model with latency LAT. It has no reset.
   always @(posedge Clock) begin
      shPipe[0] <= refShift(ShIn, ShAmount, ShShiftIn);
      for (int i = 1; i < LAT; i++) shPipe[i] <= shPipe[i-1];
   end
   assign ShOut = shPipe[LAT-1];

   // Scoreboard monitor, sampling away from the active edge.
   initial begin
      forever begin
         @(negedge Clock);
         if (ReqValid && ReqReady && !Reset)
            expQ.push_back(refShift(ReqData, ReqAmount, ReqShiftIn));
         if (RespValid && RespReady) begin
            if (expQ.size() == 0) checkVal("spuriousResp", 64'(RespData), 64'hDEAD_0000_0000_0000);
            else checkVal("respData", 64'(RespData), 64'(expQ.pop_front()));
            if (respCount == 0) firstRespCyc = cyc;
            lastRespCyc = cyc;
            respCount++;
         end
         if (int'(dut.fifoCount_r) > maxCount) maxCount = int'(dut.fifoCount_r);
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic sendReq(input logic [DW-1:0] d, input logic [4:0] a, input logic s);
      int   tries;
      logic fired;
      tries = 0;
      fired = 1'b0;
      ReqData = d; ReqAmount = a; ReqShiftIn = s; ReqValid = 1'b1;
      while (!fired && tries < 100) begin
         @(negedge Clock);
         fired = ReqReady;
         tries++;
         @(posedge Clock);
         #1;
      end
      if (tries > 1) stallCount++;
      if (!fired) checkVal("reqTimeout", 64'd0, 64'd1);
   endtask

   task automatic waitResp(output int n);
      n = 0;
      while (!RespValid && n < 50) begin
         @(posedge Clock);
         #1;
         n++;
      end
      if (!RespValid) checkVal("respTimeout", 64'd0, 64'd1);
   endtask

   // One isolated op. Checks the head against a literal, then pops it.
   task automatic runOne(input string tag, input logic [DW-1:0] d, input logic [4:0] a,
                         input logic s, input logic [DW-1:0] exp, output int lat);
      RespReady = 1'b0;
      sendReq(d, a, s);
      ReqValid = 1'b0;
      waitResp(lat);
      checkVal(tag, 64'(RespData), 64'(exp));
      RespReady = 1'b1;
      @(posedge Clock);
      #1;
      RespReady = 1'b0;
      checkVal({tag, "Drop"}, 64'(RespValid), 64'd0);
   endtask

   initial begin
      int            lat;
      int            acc;
      logic [DW-1:0] r;

      Reset = 1'b1; ReqValid = 1'b0; ReqData = '0; ReqAmount = '0;
      ReqShiftIn = 1'b0; RespReady = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      checkVal("rstReqReady",  64'(ReqReady),  64'd1);
      checkVal("rstRespValid", 64'(RespValid), 64'd0);
      checkVal("rstRespData",  64'(RespData),  64'd0);
      checkVal("rstShIn",      64'(ShIn),      64'd0);
      checkVal("rstShAmount",  64'(ShAmount),  64'd0);
      checkVal("rstShShiftIn", 64'(ShShiftIn), 64'd0);
      checkVal("rstInFlight",  64'(InFlight),  64'd0);
      Reset = 1'b0;

      // Single op, accepted at the first edge after reset release.
      runOne("singleData", 32'h0000_00F1, 5'd4, 1'b1, 32'h0000_0F1F, lat);
      checkVal("singleLatency", 64'(lat), 64'd6);
      checkVal("firstAccept", 64'(stallCount), 64'd0);

      // Boundaries.
      r = $urandom();
      runOne("amt0Fill", r, 5'd0, 1'b1, r, lat);
      runOne("amt31Fill", 32'h0000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF, lat);
      runOne("amt31Zero", 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000, lat);

      // Capture and pop at the same edge: count stays 1 and order holds.
      RespReady = 1'b0;
      sendReq(32'h1234_5678, 5'd4, 1'b0);
      sendReq(32'h0000_000F, 5'd8, 1'b1);
      ReqValid = 1'b0;
      waitResp(lat);
      checkVal("capPopHeadA", 64'(RespData), 64'h2345_6780);
      RespReady = 1'b1;
      @(posedge Clock);
      #1;
      RespReady = 1'b0;
      checkVal("capPopValid", 64'(RespValid), 64'd1);
      checkVal("capPopHeadB", 64'(RespData), 64'h0000_0FFF);
      checkVal("capPopCount", 64'(dut.fifoCount_r), 64'd1);
      RespReady = 1'b1;
      @(posedge Clock);
      #1;
      RespReady = 1'b0;
      checkVal("capPopEmpty", 64'(RespValid), 64'd0);

      // Streaming: 200 back-to-back ops with the consumer always ready.
      RespReady = 1'b1;
      respCount = 0;
      stallCount = 0;
      for (int i = 0; i < 200; i++)
         sendReq($urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      ReqValid = 1'b0;
      repeat (20) @(posedge Clock);
      #1;
      checkVal("streamStalls", 64'(stallCount), 64'd0);
      checkVal("streamCount",  64'(respCount), 64'd200);
      checkVal("streamSpan",   64'(lastRespCyc - firstRespCyc), 64'd199);
      checkVal("streamDrain",  64'(expQ.size()), 64'd0);

      // Backpressure: only DEPTH accepts while the consumer is stalled.
      RespReady = 1'b0;
      ReqValid = 1'b1;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         ReqData = $urandom(); ReqAmount = 5'($urandom_range(0, 31));
         ReqShiftIn = 1'($urandom_range(0, 1));
         @(negedge Clock);
         if (ReqReady) acc++;
         @(posedge Clock);
         #1;
      end
      checkVal("bpAccepts",  64'(acc), 64'd8);
      checkVal("bpReadyLow", 64'(ReqReady), 64'd0);
      checkVal("bpInFlight", 64'(InFlight), 64'd0);
      RespReady = 1'b1;
      @(negedge Clock);
      checkVal("bpReadyAtPop", 64'(ReqReady), 64'd0);
      @(posedge Clock);
      #1;
      RespReady = 1'b0;
      checkVal("bpReadyAfterPop", 64'(ReqReady), 64'd1);
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         ReqData = $urandom(); ReqAmount = 5'($urandom_range(0, 31));
         @(negedge Clock);
         if (ReqReady) acc++;
         @(posedge Clock);
         #1;
      end
      checkVal("bpOneMore", 64'(acc), 64'd1);
      ReqValid = 1'b0;
      RespReady = 1'b1;
      repeat (15) @(posedge Clock);
      #1;
      checkVal("bpDrain", 64'(expQ.size()), 64'd0);
      checkVal("bpEmpty", 64'(RespValid), 64'd0);

      // Reset mid-flight: three ops are discarded and must never appear.
      RespReady = 1'b0;
      for (int i = 0; i < 3; i++) sendReq($urandom(), 5'($urandom_range(0, 31)), 1'b1);
      ReqValid = 1'b0;
      repeat (2) begin
         @(posedge Clock);
         #1;
      end
      checkVal("midInFlight", 64'(InFlight), 64'd3);
      Reset = 1'b1;
      #1;
      checkVal("midRstInFlight",  64'(InFlight),  64'd0);
      checkVal("midRstReqReady",  64'(ReqReady),  64'd1);
      checkVal("midRstRespValid", 64'(RespValid), 64'd0);
      checkVal("midRstShIn",      64'(ShIn),      64'd0);
      checkVal("midRstShAmount",  64'(ShAmount),  64'd0);
      expQ.delete();
      respCount = 0;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      RespReady = 1'b1;
      repeat (20) @(posedge Clock);
      #1;
      checkVal("midNoGhost", 64'(respCount), 64'd0);

      checkVal("countBound", 64'(maxCount <= DEPTH), 64'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
